// File: rtl/fltr_pkg.sv
// Shared constants and the per-channel state record for the round-robin level filter.
package fltr_pkg;
  localparam int unsigned CNT_W        = 8;
  localparam int unsigned EVT_CH_W     = 5;
  localparam int unsigned CH_NUM_DEF   = 8;
  localparam int unsigned FLTR_CNT_DEF = 20;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef struct packed {
    logic [CNT_W-1:0] cnt;
    logic             lvl;
  } chan_state_t;
endpackage

// File: rtl/fltr_scheduler_if.sv
// Level-change event handshake between the filter scheduler and its consumer.
interface fltr_scheduler_if;
  import fltr_pkg::*;

  logic                evt_valid;
  logic                evt_ready;
  logic [EVT_CH_W-1:0] evt_ch;
  logic                evt_lvl;

  modport master (output evt_valid, output evt_ch, output evt_lvl, input evt_ready);
  modport slave  (input evt_valid, input evt_ch, input evt_lvl, output evt_ready);
endinterface

// File: rtl/fltr_chan_update.sv
// Combinational per-visit update of one channel's stability counter and level.
module fltr_chan_update
  import fltr_pkg::*;
(
  input  logic             sample,
  input  logic [CNT_W-1:0] cnt,
  input  logic             lvl,
  input  logic [CNT_W-1:0] thr,
  output logic [CNT_W-1:0] cnt_nxt,
  output logic             lvl_nxt,
  output logic             flip
);
  always_comb begin
    cnt_nxt = cnt;
    lvl_nxt = lvl;
    flip    = 1'b0;
    if (sample == lvl) begin
      cnt_nxt = '0;
    end else if (cnt >= thr) begin
      // >= so a counter left above a lowered threshold flips on its next mismatch
      lvl_nxt = ~lvl;
      cnt_nxt = '0;
      flip    = 1'b1;
    end else if (cnt != CNT_MAX) begin
      cnt_nxt = cnt + CNT_W'(1);
    end
  end
endmodule

// File: rtl/fltr_scheduler.sv
// Round-robin debounce filter: one shared update path scans all channels and reports level changes.
// Optional macro FLTR_SYNC_EN inserts a 2-flop synchronizer on signal_in.
module fltr_scheduler
  import fltr_pkg::*;
#(
  parameter int unsigned CH_NUM   = CH_NUM_DEF,
  parameter int unsigned FLTR_CNT = FLTR_CNT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [CH_NUM-1:0] signal_in,
  input  logic              cfg_we,
  input  logic [CNT_W-1:0]  cfg_thr,
  output logic [CH_NUM-1:0] signal_out,
  fltr_scheduler_if.master  evt
);
  localparam int unsigned IDX_W = $clog2(CH_NUM);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(CH_NUM - 1);

  chan_state_t         st [CH_NUM];
  logic [IDX_W-1:0]    idx;
  logic [CNT_W-1:0]    thr;
  logic [CH_NUM-1:0]   sample;
  logic                evt_valid_q;
  logic [EVT_CH_W-1:0] evt_ch_q;
  logic                evt_lvl_q;
  logic                stall;
  logic                adv;
  logic [CNT_W-1:0]    cnt_nxt;
  logic                lvl_nxt;
  logic                flip;

`ifdef FLTR_SYNC_EN
  logic [CH_NUM-1:0] sync_q1;
  logic [CH_NUM-1:0] sync_q2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= signal_in;
      sync_q2 <= sync_q1;
    end
  end

  assign sample = sync_q2;
`else
  assign sample = signal_in;
`endif

  assign stall = evt_valid_q & ~evt.evt_ready;
  assign adv   = en & ~stall;

  fltr_chan_update u_update (
    .sample  (sample[idx]),
    .cnt     (st[idx].cnt),
    .lvl     (st[idx].lvl),
    .thr     (thr),
    .cnt_nxt (cnt_nxt),
    .lvl_nxt (lvl_nxt),
    .flip    (flip)
  );

  // Scan pointer, channel state, threshold and event register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < int'(CH_NUM); k++) st[k] <= '0;
      idx         <= '0;
      thr         <= CNT_W'(FLTR_CNT);
      evt_valid_q <= 1'b0;
      evt_ch_q    <= '0;
      evt_lvl_q   <= 1'b0;
    end else begin
      if (cfg_we) thr <= cfg_thr;
      if (adv) begin
        st[idx].cnt <= cnt_nxt;
        st[idx].lvl <= lvl_nxt;
        idx         <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
      end
      if (adv && flip) begin
        evt_valid_q <= 1'b1;
        evt_ch_q    <= EVT_CH_W'(idx);
        evt_lvl_q   <= lvl_nxt;
      end else if (evt_valid_q && evt.evt_ready) begin
        evt_valid_q <= 1'b0;
      end
    end
  end

  for (genvar k = 0; k < int'(CH_NUM); k++) begin : g_out
    assign signal_out[k] = st[k].lvl;
  end

  assign evt.evt_valid = evt_valid_q;
  assign evt.evt_ch    = evt_ch_q;
  assign evt.evt_lvl   = evt_lvl_q;
endmodule

// File: tb/tb_fltr_scheduler.sv
// Randomized and directed checks of fltr_scheduler against a channel-level reference model.
module tb_fltr_scheduler;
  import fltr_pkg::*;

  localparam int CH  = 8;
  localparam int CH5 = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          en, cfg_we;
  logic [7:0]    cfg_thr;
  logic [CH-1:0] sig_in, sig_out;
  logic          en5, cfg_we5;
  logic [7:0]    cfg_thr5;
  logic [CH5-1:0] sig_in5, sig_out5;

  fltr_scheduler_if bus ();
  fltr_scheduler_if bus5 ();

  fltr_scheduler #(.CH_NUM(CH), .FLTR_CNT(20)) dut (
    .clk(clk), .rst(rst), .en(en), .signal_in(sig_in), .cfg_we(cfg_we),
    .cfg_thr(cfg_thr), .signal_out(sig_out), .evt(bus));

  fltr_scheduler #(.CH_NUM(CH5), .FLTR_CNT(20)) dut5 (
    .clk(clk), .rst(rst), .en(en5), .signal_in(sig_in5), .cfg_we(cfg_we5),
    .cfg_thr(cfg_thr5), .signal_out(sig_out5), .evt(bus5));

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model of the 8-channel instance
  int            m_cnt [CH];
  bit            m_lvl [CH];
  int            m_idx, m_thr, m_ch, m_visit;
  bit            m_valid, m_elvl, m_adv, m_flip, m_mis;
  bit            hs, hs_lvl;
  int            hs_ch;
  logic [CH-1:0] h1, h2;

  function automatic logic [CH-1:0] m_out();
    logic [CH-1:0] v;
    for (int k = 0; k < CH; k++) v[k] = m_lvl[k];
    return v;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < CH; k++) begin m_cnt[k] = 0; m_lvl[k] = 0; end
    m_idx = 0; m_thr = 20; m_ch = 0; m_valid = 0; m_elvl = 0;
    h1 = '0; h2 = '0;
  endtask

  // Predict one clock edge from the inputs currently applied, then take the edge
  task automatic tick();
    logic [CH-1:0] smp;
    bit adv;
    int k;
`ifdef FLTR_SYNC_EN
    smp = h2;
`else
    smp = sig_in;
`endif
    k   = m_idx;
    adv = en && !(m_valid && !bus.evt_ready);
    hs = m_valid && bus.evt_ready; hs_ch = m_ch; hs_lvl = m_elvl;
    m_flip = 0;
    m_mis  = smp[k] != m_lvl[k];
    if (adv) begin
      if (!m_mis) m_cnt[k] = 0;
      else if (m_cnt[k] >= m_thr) begin m_lvl[k] = !m_lvl[k]; m_cnt[k] = 0; m_flip = 1; end
      else if (m_cnt[k] < 255) m_cnt[k] = m_cnt[k] + 1;
      m_idx = (k + 1) % CH;
    end
    if (m_flip) begin m_valid = 1; m_ch = k; m_elvl = m_lvl[k]; end
    else if (hs) m_valid = 0;
    if (cfg_we) m_thr = int'(cfg_thr);
    h2 = h1; h1 = sig_in;
    m_adv = adv; m_visit = k;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1; en = 0; cfg_we = 0; cfg_thr = 0; sig_in = '0; bus.evt_ready = 1;
    en5 = 0; cfg_we5 = 0; cfg_thr5 = 0; sig_in5 = '0; bus5.evt_ready = 1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (sig_out !== '0) begin errors++; $display("FAIL reset_out got=%h exp=0", sig_out); end
    checks++; if (bus.evt_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", bus.evt_valid); end
    checks++; if (bus.evt_ch !== 5'd0 || bus.evt_lvl !== 1'b0)
      begin errors++; $display("FAIL reset_evt got ch=%0d lvl=%b exp ch=0 lvl=0", bus.evt_ch, bus.evt_lvl); end
    rst = 0;
    model_reset();
  endtask

  task automatic test_ch3_rise();
    int visits = 0;
    bit seen = 0;
    en = 1; bus.evt_ready = 1; sig_in = 8'h08;
    for (int i = 0; i < 400 && !seen; i++) begin
      tick();
      if (m_adv && m_visit == 3 && m_mis) visits++;
      checks++; if (sig_out !== m_out()) begin errors++; $display("FAIL ch3_out got=%h exp=%h", sig_out, m_out()); end
      checks++; if (bus.evt_valid !== m_valid) begin errors++; $display("FAIL ch3_valid got=%b exp=%b", bus.evt_valid, m_valid); end
      if (bus.evt_valid === 1'b1) begin
        seen = 1;
        checks++; if (bus.evt_ch !== 5'd3 || bus.evt_lvl !== 1'b1 || visits != 21 || sig_out[3] !== 1'b1)
          begin errors++; $display("FAIL ch3_event got ch=%0d lvl=%b visits=%0d out3=%b exp ch=3 lvl=1 visits=21 out3=1", bus.evt_ch, bus.evt_lvl, visits, sig_out[3]); end
      end
    end
    checks++; if (!seen) begin errors++; $display("FAIL ch3_timeout got=no_event exp=event"); end
    tick();
    checks++; if (bus.evt_valid !== 1'b0) begin errors++; $display("FAIL ch3_one_cycle got=%b exp=0", bus.evt_valid); end
  endtask

  task automatic test_glitch();
    int visits = 0;
    sig_in = 8'h09;
    for (int i = 0; i < 400 && visits < 20; i++) begin
      tick();
      if (m_adv && m_visit == 0 && m_mis) visits++;
      checks++; if (bus.evt_valid !== 1'b0) begin errors++; $display("FAIL glitch_no_evt got=%b exp=0", bus.evt_valid); end
    end
    sig_in = 8'h08;
    repeat (16) begin
      tick();
      checks++; if (sig_out !== m_out() || bus.evt_valid !== 1'b0)
        begin errors++; $display("FAIL glitch_state got out=%h v=%b exp out=%h v=0", sig_out, bus.evt_valid, m_out()); end
    end
    checks++; if (sig_out[0] !== 1'b0 || int'(dut.st[0].cnt) != 0 || visits != 20)
      begin errors++; $display("FAIL glitch_end got out0=%b cnt0=%0d visits=%0d exp 0 0 20", sig_out[0], dut.st[0].cnt, visits); end
  endtask

  task automatic test_stall();
    int got_ch [$];
    bit got_lvl [$];
    cfg_we = 1; cfg_thr = 8'd2; tick(); cfg_we = 0;
    for (int i = 0; i < 20 && m_idx != 0; i++) tick();
    bus.evt_ready = 0; sig_in = 8'h2C;
    for (int i = 0; i < 60; i++) begin
      tick();
      checks++; if (sig_out !== m_out() || bus.evt_valid !== m_valid)
        begin errors++; $display("FAIL stall_state got out=%h v=%b exp out=%h v=%b", sig_out, bus.evt_valid, m_out(), m_valid); end
    end
    checks++; if (bus.evt_valid !== 1'b1 || bus.evt_ch !== 5'd2 || sig_out[5] !== 1'b0)
      begin errors++; $display("FAIL stall_hold got v=%b ch=%0d out5=%b exp v=1 ch=2 out5=0", bus.evt_valid, bus.evt_ch, sig_out[5]); end
    bus.evt_ready = 1;
    for (int i = 0; i < 100 && got_ch.size() < 2; i++) begin
      tick();
      if (hs) begin got_ch.push_back(hs_ch); got_lvl.push_back(hs_lvl); end
      checks++; if (sig_out !== m_out() || bus.evt_valid !== m_valid)
        begin errors++; $display("FAIL drain_state got out=%h v=%b exp out=%h v=%b", sig_out, bus.evt_valid, m_out(), m_valid); end
    end
    checks++; if (got_ch.size() != 2) begin errors++; $display("FAIL drain_count got=%0d exp=2", got_ch.size()); end
    else begin
      checks++; if (got_ch[0] != 2 || got_ch[1] != 5 || !got_lvl[0] || !got_lvl[1])
        begin errors++; $display("FAIL drain_order got=%0d,%0d exp=2,5", got_ch[0], got_ch[1]); end
    end
  endtask

  task automatic test_thr();
    int visits = 0;
    bit done = 0;
    cfg_we = 1; cfg_thr = 8'd0; tick(); cfg_we = 0;
    sig_in = sig_in | 8'h02;
    for (int i = 0; i < 30 && !done; i++) begin
      tick();
      if (m_adv && m_visit == 1 && m_mis) begin
        done = 1;
        checks++; if (bus.evt_valid !== 1'b1 || bus.evt_ch !== 5'd1 || sig_out[1] !== 1'b1)
          begin errors++; $display("FAIL thr0_flip got v=%b ch=%0d out1=%b exp 1 1 1", bus.evt_valid, bus.evt_ch, sig_out[1]); end
      end
    end
    checks++; if (!done) begin errors++; $display("FAIL thr0_timeout got=no_visit exp=visit"); end
    cfg_we = 1; cfg_thr = 8'd20; tick(); cfg_we = 0;
    sig_in = sig_in | 8'h40;
    for (int i = 0; i < 400 && visits < 15; i++) begin
      tick();
      if (m_adv && m_visit == 6 && m_mis) visits++;
    end
    checks++; if (int'(dut.st[6].cnt) != 15 || sig_out[6] !== 1'b0)
      begin errors++; $display("FAIL thr_cnt15 got cnt=%0d out6=%b exp 15 0", dut.st[6].cnt, sig_out[6]); end
    en = 0; cfg_we = 1; cfg_thr = 8'd10; tick(); cfg_we = 0; en = 1;
    done = 0;
    for (int i = 0; i < 30 && !done; i++) begin
      tick();
      if (m_adv && m_visit == 6) begin
        done = 1;
        checks++; if (bus.evt_valid !== 1'b1 || bus.evt_ch !== 5'd6 || sig_out[6] !== 1'b1)
          begin errors++; $display("FAIL thr_lower_flip got v=%b ch=%0d out6=%b exp 1 6 1", bus.evt_valid, bus.evt_ch, sig_out[6]); end
      end
    end
    checks++; if (!done) begin errors++; $display("FAIL thr_lower_timeout got=no_visit exp=visit"); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      sig_in        = CH'($urandom);
      en            = ($urandom_range(0, 9) < 8);
      bus.evt_ready = ($urandom_range(0, 2) != 0);
      cfg_we        = ($urandom_range(0, 49) == 0);
      cfg_thr       = 8'($urandom_range(0, 4));
      tick();
      checks++; if (sig_out !== m_out()) begin errors++; $display("FAIL rand_out t=%0d got=%h exp=%h", i, sig_out, m_out()); end
      checks++; if (bus.evt_valid !== m_valid) begin errors++; $display("FAIL rand_valid t=%0d got=%b exp=%b", i, bus.evt_valid, m_valid); end
      if (m_valid) begin
        checks++; if (bus.evt_ch !== 5'(m_ch) || bus.evt_lvl !== m_elvl)
          begin errors++; $display("FAIL rand_evt t=%0d got ch=%0d lvl=%b exp ch=%0d lvl=%b", i, bus.evt_ch, bus.evt_lvl, m_ch, m_elvl); end
      end
    end
    cfg_we = 0; bus.evt_ready = 1;
  endtask

  task automatic test_scan5();
    int m5_idx = 0;
    int m5_cnt [CH5];
    for (int k = 0; k < CH5; k++) m5_cnt[k] = 0;
    en = 0; sig_in5 = '1; en5 = 1;
    for (int i = 0; i < 12; i++) begin
      m5_cnt[m5_idx] = m5_cnt[m5_idx] + 1;
      m5_idx = (m5_idx + 1) % CH5;
      tick();
      checks++; if (int'(dut5.idx) != m5_idx) begin errors++; $display("FAIL scan5_idx got=%0d exp=%0d", dut5.idx, m5_idx); end
    end
    en5 = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++; if (int'(dut5.idx) != m5_idx) begin errors++; $display("FAIL scan5_freeze_idx got=%0d exp=%0d", dut5.idx, m5_idx); end
    end
    for (int k = 0; k < CH5; k++) begin
      checks++; if (int'(dut5.st[k].cnt) != m5_cnt[k])
        begin errors++; $display("FAIL scan5_cnt ch=%0d got=%0d exp=%0d", k, dut5.st[k].cnt, m5_cnt[k]); end
    end
    checks++; if (sig_out5 !== '0 || bus5.evt_valid !== 1'b0)
      begin errors++; $display("FAIL scan5_out got out=%h v=%b exp 0 0", sig_out5, bus5.evt_valid); end
  endtask

  task automatic test_async_reset();
    en = 1; bus.evt_ready = 1; cfg_we = 1; cfg_thr = 8'd0; tick(); cfg_we = 0;
    bus.evt_ready = 0; sig_in = ~m_out();
    for (int i = 0; i < 30 && !m_valid; i++) tick();
    checks++; if (bus.evt_valid !== 1'b1 || sig_out !== m_out())
      begin errors++; $display("FAIL pre_reset got v=%b out=%h exp v=1 out=%h", bus.evt_valid, sig_out, m_out()); end
    #2 rst = 1;
    #1;
    checks++; if (bus.evt_valid !== 1'b0 || sig_out !== '0)
      begin errors++; $display("FAIL async_reset got v=%b out=%h exp v=0 out=0", bus.evt_valid, sig_out); end
    @(posedge clk); #1;
    rst = 0; en = 0; bus.evt_ready = 1; sig_in = '0;
    model_reset();
    tick();
    checks++; if (bus.evt_ch !== 5'd0 || bus.evt_lvl !== 1'b0 || int'(dut.idx) != 0)
      begin errors++; $display("FAIL post_reset got ch=%0d lvl=%b idx=%0d exp 0 0 0", bus.evt_ch, bus.evt_lvl, dut.idx); end
  endtask

  initial begin
    test_reset();
    test_ch3_rise();
    test_glitch();
    test_stall();
    test_thr();
    test_random();
    test_scan5();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fltr_scheduler.md
FLTR_SCHEDULER -- requirements
Module: fltr_scheduler

Interface
Parameters:
REQ-001 The block SHALL have parameter CH_NUM, default 8: number of filtered input channels, 2..32, need not be a power of two.
REQ-002 The block SHALL have parameter FLTR_CNT, default 20: reset value of the stability threshold, 8-bit.
Ports:
REQ-003 The block SHALL have port clk  in  1  the single clock; all logic on its rising edge.
REQ-004 The block SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-005 The block SHALL have port en  in  1  scan enable; low holds all channel state.
REQ-006 The block SHALL have port signal_in  in  CH_NUM  raw channel inputs.
REQ-007 The block SHALL have port cfg_we  in  1  threshold write strobe.
REQ-008 The block SHALL have port cfg_thr  in  8  new threshold value.
REQ-009 The block SHALL have port signal_out  out  CH_NUM  filtered levels.
REQ-010 The block SHALL have port evt_valid  out  1  level-change event pending.
REQ-011 The block SHALL have port evt_ready  in  1  consumer accepts the event.
REQ-012 The block SHALL have port evt_ch  out  5  channel index of the event.
REQ-013 The block SHALL have port evt_lvl  out  1  new level of that channel.

Function
REQ-014 One shared update datapath SHALL serve all channels round-robin: scan index idx visits one channel per advancing cycle, 0..CH_NUM-1, then wraps to 0.
REQ-015 Per-channel state SHALL be an 8-bit counter cnt[k] plus the level signal_out[k].
REQ-016 On a visit, if sample equals signal_out[idx], cnt[idx] SHALL clear to 0.
REQ-017 If the sample differs and cnt[idx] >= thr, signal_out[idx] SHALL toggle at that edge, cnt[idx] SHALL clear, and an event SHALL be loaded (evt_ch=idx, evt_lvl=new level, evt_valid=1).
REQ-018 Otherwise, on a mismatching sample, cnt[idx] SHALL increment, saturating at 255.
REQ-019 Consequence: a level change SHALL require thr+1 consecutive mismatching visits; thr=0 flips on the first mismatching visit.
REQ-020 The scan SHALL advance only when en=1 and no stall is present.
REQ-021 Stall: evt_valid=1 and evt_ready=0; idx, counters and signal_out SHALL hold, and evt_ch/evt_lvl SHALL stay stable.
REQ-022 With evt_valid=1 and evt_ready=1, the scan SHALL proceed in the same cycle; a new flip at that edge SHALL reload the event, keeping evt_valid=1; otherwise evt_valid SHALL drop.
REQ-023 cfg_we=1 SHALL load cfg_thr into thr at that edge; the new value SHALL take effect from the next visit.
REQ-024 Counters above a newly lowered thr SHALL flip on their next mismatching visit, because the compare is >=.
REQ-025 en=0 SHALL NOT drop a pending event; the handshake SHALL still complete.

Reset
REQ-026 On rst=1, asynchronously: signal_out=0, all cnt=0, idx=0, evt_valid=0, evt_ch=0, evt_lvl=0, thr=FLTR_CNT, synchronizer flops=0.
REQ-027 Reset mid-stall SHALL discard the pending event with no partial state retained.

Configuration
REQ-028 With macro FLTR_SYNC_EN defined, signal_in SHALL pass through a 2-flop synchronizer per channel before sampling, adding 2 cycles of latency.
REQ-029 Without FLTR_SYNC_EN, signal_in SHALL be sampled directly.

Structure
REQ-030 Package fltr_pkg SHALL hold CNT_W=8, the default CH_NUM and FLTR_CNT values, and the channel-state typedef {cnt, lvl}.
REQ-031 Sub-module fltr_chan_update SHALL be purely combinational: (sample, cnt, lvl, thr) -> (cnt_nxt, lvl_nxt, flip).

Verification
REQ-032 Reset, CH_NUM=8, thr=20, ch3 held high, evt_ready=1 -> signal_out[3] rises after the 21st visit to ch3; evt_ch=3, evt_lvl=1 for one cycle.
REQ-033 Ch0 glitch high for 20 visits, then low -> no event, signal_out[0] stays 0, cnt[0] returns to 0.
REQ-034 evt_ready=0 while ch2 and ch5 flip -> scan stalls on ch2's event; raising evt_ready delivers ch2, then ch5, with none lost.
REQ-035 cfg_thr=0 written -> next mismatching visit flips the channel; counter at 15 with thr lowered to 10 -> flips on the next mismatching visit.
REQ-036 CH_NUM=5 -> idx sequence 0..4,0 with no out-of-range visit; en=0 for 10 cycles freezes idx and all counters.
REQ-037 rst asserted while evt_valid=1 -> evt_valid=0 and signal_out=0 immediately, without waiting for a clock edge.
